sram_responder: RTL
===================

// Module: sram_responder
// PURPOSE
//   Memory-side end of the SLC-3 SRAM bus: a synthesizable responder that models the external
//   1Mx16 asynchronous SRAM as seen by the CPU, Mem2IO and tristate path. Samples the active-low
//   CE/UB/LB/OE/WE strobes and ADDR on Clk, stores writes into an on-chip word array, and drives
//   read data back onto the shared Data bus after a fixed latency. Used as an SRAM stand-in for
//   on-chip builds and as the memory model in the SLC-3 top-level bench.
// PARAMETERS
//   DEPTH_W   10   log2 of stored words; ADDR[DEPTH_W-1:0] indexes the array, upper bits ignored
//   READ_LAT  2    Clk cycles from the sampled read request to Data driven (1..7)
// PORTS
//   Clk       in     1   system clock, all state updates on the rising edge
//   Reset     in     1   asynchronous, active-low reset
//   CE        in     1   chip enable, active-low
//   UB        in     1   upper byte lane enable (Data[15:8]), active-low
//   LB        in     1   lower byte lane enable (Data[7:0]), active-low
//   OE        in     1   output enable, active-low
//   WE        in     1   write enable, active-low
//   ADDR      in     20  word address
//   Data      inout  16  shared bidirectional data bus; this block drives it only in READ_DRIVE
//   Rd_Valid  out    1   high on every cycle this block drives Data
//   Wr_Strobe out    1   high for one cycle after each committed write
// BEHAVIOUR
//   Reset (Reset=0, async): state IDLE, Data released (16'hZZZZ), Rd_Valid=0, Wr_Strobe=0,
//     latency counter=0, latched address=0. Array contents are NOT cleared and survive reset.
//   Request decode at each rising edge, from the sampled strobes:
//     WRITE : CE=0 & WE=0 (WE overrides OE)     READ : CE=0 & WE=1 & OE=0     NONE : otherwise
//   States: IDLE, READ_WAIT, READ_DRIVE.
//   IDLE: READ -> latch ADDR, counter=READ_LAT-1, go READ_WAIT (READ_LAT=1: go straight to
//     READ_DRIVE). WRITE -> commit at this edge, stay IDLE. NONE -> stay.
//   READ_WAIT: READ with unchanged address -> decrement counter; at 0 go READ_DRIVE.
//     READ with changed address -> re-latch, reload counter (restart). WRITE -> commit, go IDLE.
//     NONE -> go IDLE.
//   READ_DRIVE: Data driven from a registered copy of mem[latched addr]; Rd_Valid=1.
//     Per-lane drive: Data[15:8] driven only if UB=0, Data[7:0] only if LB=0; disabled lanes Z.
//     Lane enables are sampled at the same edge as the request, not applied combinationally.
//     READ with same address -> stay and keep driving. READ with new address -> release bus,
//     re-latch, go READ_WAIT (full latency again). WRITE -> release bus, commit write, go IDLE.
//     NONE -> release bus, go IDLE. Release takes effect from the same edge (registered enable).
//   Write commit: mem[ADDR[DEPTH_W-1:0]][15:8] <= Data[15:8] if UB=0; [7:0] <= Data[7:0] if LB=0.
//     UB=LB=1 writes nothing but still pulses Wr_Strobe. A write is taken on every cycle WE is
//     sampled low (a held WE rewrites the current ADDR/Data each cycle, one Wr_Strobe per cycle).
//   This block never drives Data in a cycle where WE was sampled low (no bus contention).
//   Address aliasing: ADDR and ADDR + k*2^DEPTH_W hit the same word; no error is flagged.
//   Read-after-write to the same address returns the newly written data (the write commits
//     before the read request is latched on a later edge).
//   Reset asserted mid-read: bus released immediately (async), Rd_Valid drops immediately.
// TESTING
//   1) Reset, write 16'hBEEF to addr 0x0005 (CE=0,WE=0,UB=LB=0) -> Wr_Strobe=1 next cycle;
//      read 0x0005 with OE=0 -> Data=16'hBEEF, Rd_Valid=1 exactly READ_LAT cycles later.
//   2) Byte lanes: mem[0x10]=16'h1234; write 16'hAB00 with UB=0,LB=1 -> read returns 16'hAB34;
//      read with UB=1,LB=0 -> Data[7:0]=8'h34, Data[15:8]=Z.
//   3) Address change mid-latency: read 0x0001, change to 0x0002 on wait cycle 1 -> no drive
//      until READ_LAT cycles after change; then mem[0x0002] appears, never mem[0x0001].
//   4) WE and OE both low while in READ_DRIVE -> Data released same edge, write commits,
//      Rd_Valid=0, no cycle where both CPU tristate and responder drive the bus.
//   5) Aliasing (DEPTH_W=10): write 16'h00C3 to 0x00400 -> read of 0x00000 returns 16'h00C3.
//   6) Assert Reset during READ_DRIVE -> Data=Z and Rd_Valid=0 without waiting for Clk;
//      after release, read of previously written 0x0005 still returns 16'hBEEF.

Source files
------------

// File: rtl/sram_responder.sv
// SLC-3 SRAM bus responder: on-chip word array behind the async SRAM strobes,
// returning read data on the shared Data bus after a fixed latency.
module sram_responder #(
  parameter int DEPTH_W  = 10,
  parameter int READ_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        Rd_Valid,
  output logic        Wr_Strobe
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE
  } state_e;

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);
  localparam state_e LD_STATE = (READ_LAT == 1) ? READ_DRIVE : READ_WAIT;

  logic [15:0] mem_q [DEPTH];

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               hi_q, hi_d;
  logic               lo_q, lo_d;
  logic               ws_q;

  logic               is_wr, is_rd, same;
  logic [DEPTH_W-1:0] idx;
  logic               unused_addr;

  assign is_wr = ~CE & ~WE;
  assign is_rd = ~CE & WE & ~OE;
  assign idx   = ADDR[DEPTH_W-1:0];
  assign same  = (idx == addr_q);

  // Upper address bits alias onto the same word by design.
  assign unused_addr = ^ADDR[19:DEPTH_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    hi_d    = 1'b0;
    lo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_rd) begin
          addr_d  = idx;
          cnt_d   = LAT_M1;
          state_d = LD_STATE;
        end
      end
      READ_WAIT: begin
        if (is_rd && same) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = READ_DRIVE;
        end else if (is_rd) begin
          addr_d  = idx;
          cnt_d   = LAT_M1;
          state_d = LD_STATE;
        end else begin
          state_d = IDLE;
        end
      end
      READ_DRIVE: begin
        if (is_rd && !same) begin
          addr_d  = idx;
          cnt_d   = LAT_M1;
          state_d = LD_STATE;
        end else if (!is_rd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Entering or holding READ_DRIVE always has addr_d == idx.
    if (state_d == READ_DRIVE) begin
      rdata_d = mem_q[idx];
      hi_d    = ~UB;
      lo_d    = ~LB;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ws_q    <= is_wr;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (is_wr && Reset) begin
      if (!UB) mem_q[idx][15:8] <= Data[15:8];
      if (!LB) mem_q[idx][7:0]  <= Data[7:0];
    end
  end

  assign Data[15:8] = hi_q ? rdata_q[15:8] : 8'hzz;
  assign Data[7:0]  = lo_q ? rdata_q[7:0]  : 8'hzz;

  assign Rd_Valid  = (state_q == READ_DRIVE);
  assign Wr_Strobe = ws_q;

endmodule
